// File: rtl/faccel_bus_master_pkg.sv
// Shared types and constants for the factorial-accelerator bus master.
// Register map offsets and status bit positions match the accelerator's register file.
package faccel_bus_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_N,
    WR_GO,
    POLL,
    RD_RES,
    DONE
  } state_t;

  localparam logic [3:0] OFF_N    = 4'h0;
  localparam logic [3:0] OFF_GO   = 4'h4;
  localparam logic [3:0] OFF_STAT = 4'h8;
  localparam logic [3:0] OFF_RES  = 4'hC;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;

  localparam logic [31:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [3:0] off);
    return base + {28'd0, off};
  endfunction

endpackage

// File: rtl/faccel_bus_master_if.sv
// Job handshake plus memory-mapped bus between controller, bus master and SoC.
// The master modport is the bus initiator; the slave modport is the harness/SoC side.
interface faccel_bus_master_if;

  logic        start;
  logic [31:0] op_n;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;

  logic [31:0] addr;
  logic [31:0] write_data;
  logic        WE;
  logic [31:0] rd_data;

  modport master (
    input  start, op_n, rd_data,
    output busy, done, result, err, addr, write_data, WE
  );

  modport slave (
    output start, op_n, rd_data,
    input  busy, done, result, err, addr, write_data, WE
  );

endinterface

// File: rtl/faccel_bus_master_poll_timer.sv
// Saturating poll counter used for the status-poll timeout (FACCEL_TIMEOUT_EN builds).
// hit flags the enabled poll cycle whose increment lands the count on LIMIT.
module faccel_bus_master_poll_timer #(
  parameter int CNT_W = 11,
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // Saturates at all-ones instead of wrapping so a stuck poll never looks fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign hit = en && (count == LAST);

endmodule

// File: rtl/faccel_bus_master.sv
// Bus initiator running one factorial-accelerator job: write n, write go, poll, read result.
// Define FACCEL_TIMEOUT_EN to abort polling after TIMEOUT_CYCLES with an error result.
module faccel_bus_master
  import faccel_bus_master_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0800,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          CNT_W          = 11
) (
  input  logic               clk,
  input  logic               reset,
  faccel_bus_master_if.master bus
);

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
    $error("CNT_W is too narrow to reach TIMEOUT_CYCLES");
  end

  state_t      state;
  state_t      next_state;
  logic [31:0] addr_next;
  logic [31:0] wdata_next;
  logic        we_next;
  logic        err_tmp;
  logic        stat_done;
  logic        timeout_hit;

  assign stat_done = bus.rd_data[STAT_DONE];

`ifdef FACCEL_TIMEOUT_EN
  logic poll_clr;
  logic poll_en;

  assign poll_clr = (state == IDLE) && bus.start;
  assign poll_en  = (state == POLL) && !stat_done;

  faccel_bus_master_poll_timer #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_poll_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (poll_clr),
    .en    (poll_en),
    .hit   (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bus values are decoded from next_state so they are registered alongside the state.
  always_comb begin
    next_state = state;
    addr_next  = '0;
    wdata_next = '0;
    we_next    = 1'b0;

    case (state)
      IDLE:    if (bus.start) next_state = WR_N;
      WR_N:    next_state = WR_GO;
      WR_GO:   next_state = POLL;
      POLL: begin
        if (stat_done) begin
          next_state = RD_RES;
        end else if (timeout_hit) begin
          next_state = DONE;
        end
      end
      RD_RES:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    case (next_state)
      WR_N: begin
        addr_next  = reg_addr(BASE_ADDR, OFF_N);
        wdata_next = bus.op_n;
        we_next    = 1'b1;
      end
      WR_GO: begin
        addr_next  = reg_addr(BASE_ADDR, OFF_GO);
        wdata_next = 32'd1;
        we_next    = 1'b1;
      end
      POLL:    addr_next = reg_addr(BASE_ADDR, OFF_STAT);
      RD_RES:  addr_next = reg_addr(BASE_ADDR, OFF_RES);
      default: ;
    endcase
  end

  // The status read clears the responder's sticky flag, so the first observed done is final.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.addr       <= '0;
      bus.write_data <= '0;
      bus.WE         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.result     <= '0;
      bus.err        <= 1'b0;
      err_tmp        <= 1'b0;
    end else begin
      bus.addr       <= addr_next;
      bus.write_data <= wdata_next;
      bus.WE         <= we_next;
      bus.busy       <= (next_state != IDLE);
      bus.done       <= (next_state == DONE);

      if ((state == POLL) && stat_done) begin
        err_tmp <= bus.rd_data[STAT_ERR];
      end

      if (state == RD_RES) begin
        bus.result <= bus.rd_data;
        bus.err    <= err_tmp;
      end else if ((state == POLL) && (next_state == DONE)) begin
        bus.result <= TIMEOUT_RESULT;
        bus.err    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_faccel_bus_master.sv
// Self-checking bench for faccel_bus_master with a behavioural accelerator responder.
// Define FACCEL_TIMEOUT_EN to also exercise the poll timeout path.
module tb_faccel_bus_master;

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  faccel_bus_master_if bus_if();

  faccel_bus_master #(
    .BASE_ADDR      (32'h0000_0800),
    .TIMEOUT_CYCLES (8),
    .CNT_W          (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int          vectors;
  int          miscompares;
  int          done_pulses;
  int          stat_reads;
  int          edges;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] w_addr_q[$];
  logic [31:0] w_data_q[$];

  int          acc_lat;
  bit          acc_stuck;
  int          acc_cnt;
  logic [31:0] acc_n;
  logic [31:0] acc_result;
  logic        acc_done;
  logic        acc_err;
  logic [31:0] soc_rd;

  function automatic logic [31:0] fact32(input logic [31:0] n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 2; i <= int'(n); i++) p = p * 32'(i);
    return p;
  endfunction

  // Read data is combinational from the address, as on the SoC port.
  always_comb begin
    soc_rd = 32'd0;
    case (bus_if.addr)
      32'h0000_0800: soc_rd = acc_n;
      32'h0000_0808: soc_rd = {30'd0, acc_err, acc_done};
      32'h0000_080C: soc_rd = acc_result;
      default:       soc_rd = 32'd0;
    endcase
  end

  assign bus_if.rd_data = soc_rd;

  // Accelerator model: go starts a countdown, done is sticky until a status read.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_n      <= 32'd0;
      acc_result <= 32'd0;
      acc_done   <= 1'b0;
      acc_err    <= 1'b0;
      acc_cnt    <= 0;
    end else begin
      if (!bus_if.WE && (bus_if.addr == 32'h0000_0808) && acc_done) acc_done <= 1'b0;
      if (bus_if.WE && (bus_if.addr == 32'h0000_0800)) acc_n <= bus_if.write_data;
      if (bus_if.WE && (bus_if.addr == 32'h0000_0804) && bus_if.write_data[0]) begin
        acc_result <= fact32(acc_n);
        acc_err    <= (acc_n > 32'd12);
        if ((acc_lat == 0) && !acc_stuck) acc_done <= 1'b1;
        else acc_cnt <= acc_lat;
      end else if (acc_cnt != 0) begin
        acc_cnt <= acc_cnt - 1;
        if ((acc_cnt == 1) && !acc_stuck) acc_done <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && bus_if.WE) begin
      w_addr_q.push_back(bus_if.addr);
      w_data_q.push_back(bus_if.write_data);
    end
    if (!reset && !bus_if.WE && (bus_if.addr == 32'h0000_0808)) stat_reads++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus_if.done) begin
      done_pulses++;
      checkOutput("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        checkOutput("result", bus_if.result, mon_e.res);
        checkOutput("err", {31'd0, bus_if.err}, {31'd0, mon_e.err});
      end
    end
  end

  function automatic int count_writes(input logic [31:0] a);
    int c;
    c = 0;
    foreach (w_addr_q[i]) if (w_addr_q[i] == a) c++;
    return c;
  endfunction

  // Raises start for one cycle just after an edge; returns one ns after the accepting edge.
  task automatic applyStimulus(input logic [31:0] op, input logic [31:0] exp_res, input logic exp_err);
    exp_t e;
    @(posedge clk); #1;
    bus_if.start = 1'b1;
    bus_if.op_n  = op;
    e.res = exp_res;
    e.err = exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    checkOutput("wr_n_busy", {31'd0, bus_if.busy}, 32'd1);
    checkOutput("wr_n_we", {31'd0, bus_if.WE}, 32'd1);
    checkOutput("wr_n_addr", bus_if.addr, 32'h0000_0800);
    checkOutput("wr_n_data", bus_if.write_data, op);
  endtask

  task automatic waitDone(input int budget, output int n_edges);
    n_edges = 1;
    while (!bus_if.done && (n_edges < budget)) begin
      @(posedge clk); #1;
      n_edges++;
    end
    checkOutput("done_seen", {31'd0, bus_if.done}, 32'd1);
  endtask

  task automatic finishJob();
    checkOutput("busy_in_done", {31'd0, bus_if.busy}, 32'd1);
    @(posedge clk); #1;
    checkOutput("busy_after_done", {31'd0, bus_if.busy}, 32'd0);
    checkOutput("done_one_cycle", {31'd0, bus_if.done}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_pulses = 0;
    stat_reads  = 0;
    acc_lat     = 4;
    acc_stuck   = 1'b0;
    bus_if.start = 1'b0;
    bus_if.op_n  = 32'd0;
    reset = 1'b1;
    #12;
    checkOutput("rst_addr", bus_if.addr, 32'd0);
    checkOutput("rst_wdata", bus_if.write_data, 32'd0);
    checkOutput("rst_we", {31'd0, bus_if.WE}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    checkOutput("rst_done", {31'd0, bus_if.done}, 32'd0);
    checkOutput("rst_result", bus_if.result, 32'd0);
    checkOutput("rst_err", {31'd0, bus_if.err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] job n=5");
    w_addr_q.delete();
    w_data_q.delete();
    applyStimulus(32'd5, 32'd120, 1'b0);
    waitDone(60, edges);
    finishJob();
    checkOutput("wr_log_len", 32'(w_addr_q.size()), 32'd2);
    checkOutput("wr0_addr", w_addr_q[0], 32'h0000_0800);
    checkOutput("wr0_data", w_data_q[0], 32'd5);
    checkOutput("wr1_addr", w_addr_q[1], 32'h0000_0804);
    checkOutput("wr1_data", w_data_q[1], 32'd1);
    checkOutput("idle_addr", bus_if.addr, 32'd0);
    checkOutput("result_held", bus_if.result, 32'd120);

    $display("[TB] job n=13 error range");
    acc_lat = 3;
    applyStimulus(32'd13, 32'h7328_CC00, 1'b1);
    waitDone(60, edges);
    finishJob();

    $display("[TB] job n=10");
    acc_lat = 2;
    applyStimulus(32'd10, 32'd3628800, 1'b0);
    waitDone(60, edges);
    finishJob();

    $display("[TB] start while busy");
    acc_lat = 6;
    w_addr_q.delete();
    w_data_q.delete();
    done_pulses = 0;
    applyStimulus(32'd4, 32'd24, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus_if.start = 1'b1;
    bus_if.op_n  = 32'd9;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    waitDone(60, edges);
    finishJob();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("one_n_write", 32'(count_writes(32'h0000_0800)), 32'd1);
    checkOutput("one_done_pulse", 32'(done_pulses), 32'd1);

    $display("[TB] reset during poll");
    acc_lat = 20;
    applyStimulus(32'd7, 32'd5040, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    checkOutput("pre_rst_addr", bus_if.addr, 32'h0000_0808);
    reset = 1'b1;
    #1;
    checkOutput("arst_we", {31'd0, bus_if.WE}, 32'd0);
    checkOutput("arst_busy", {31'd0, bus_if.busy}, 32'd0);
    checkOutput("arst_done", {31'd0, bus_if.done}, 32'd0);
    checkOutput("arst_addr", bus_if.addr, 32'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    acc_lat = 3;
    applyStimulus(32'd3, 32'd6, 1'b0);
    waitDone(60, edges);
    finishJob();

    $display("[TB] done on first poll");
    acc_lat = 0;
    applyStimulus(32'd1, 32'd1, 1'b0);
    waitDone(60, edges);
    checkOutput("first_poll_latency", 32'(edges), 32'd5);
    finishJob();

`ifdef FACCEL_TIMEOUT_EN
    $display("[TB] poll timeout");
    acc_stuck  = 1'b1;
    acc_lat    = 0;
    stat_reads = 0;
    applyStimulus(32'd9, 32'hFFFF_FFFF, 1'b1);
    waitDone(60, edges);
    checkOutput("timeout_latency", 32'(edges), 32'd11);
    finishJob();
    checkOutput("timeout_polls", 32'(stat_reads), 32'd8);
    acc_stuck = 1'b0;
`endif

    repeat (3) @(posedge clk);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
